regfile_writeback: RTL and testbench

Writeback stage that owns the single write port of the 8x8 register file and its conditional bit. It merges single-cycle ALU results with variable-latency load results from the memory side. ALU writes take priority; load results are held in a 2-entry queue and drained on free cycles. A per-register pending mask lets decode stall on outstanding loads.

---
 rtl/regfile_writeback.sv | 151 +++++++++++++++
 tb/tb_regfile_writeback.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_writeback : single regfile write port arbitrating ALU results over a
//                     2-entry in-order load queue, plus the conditional bit.
// Revision 1.0
// ----------------------------------------------------------------------------
module regfile_writeback (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       alu_valid_i,
  input  logic [2:0] alu_addr_i,
  input  logic [7:0] alu_data_i,
  input  logic       alu_cb_valid_i,
  input  logic       alu_cb_i,
  input  logic       mem_valid_i,
  output logic       mem_ready_o,
  input  logic [2:0] mem_addr_i,
  input  logic [7:0] mem_data_i,
  output logic       write_o,
  output logic [2:0] write_addr_o,
  output logic [7:0] write_data_o,
  output logic       write_CB_o,
  output logic       cb_data_o,
  output logic [7:0] busy_o
);

  localparam int DEPTH = 2;

  // Queue storage; index 0 is the head. Unoccupied slots always have live=0.
  logic [1:0]       count_q, count_d;
  logic [DEPTH-1:0] live_q, live_d;
  logic [2:0]       addr_q [DEPTH];
  logic [2:0]       addr_d [DEPTH];
  logic [7:0]       data_q [DEPTH];
  logic [7:0]       data_d [DEPTH];

  logic       write_q, write_d;
  logic [2:0] write_addr_q, write_addr_d;
  logic [7:0] write_data_q, write_data_d;
  logic       write_cb_q, write_cb_d;
  logic       cb_data_q, cb_data_d;

  logic             push, pop, pop_live;
  logic [DEPTH-1:0] live_cancel;
  logic [1:0]       count_after_pop;
  logic             push_idx;
  logic [7:0]       busy;

  assign mem_ready_o = (count_q < 2'd2);
  assign push        = mem_valid_i && mem_ready_o;
  assign pop         = !alu_valid_i && (count_q != 2'd0);
  assign pop_live    = pop && live_q[0];

  // Kill older loads to the ALU target so they cannot overwrite the newer value.
  always_comb begin
    live_cancel = live_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_valid_i && live_q[i] && (addr_q[i] == alu_addr_i)) begin
        live_cancel[i] = 1'b0;
      end
    end
  end

  always_comb begin
    live_d          = live_cancel;
    addr_d          = addr_q;
    data_d          = data_q;
    count_after_pop = count_q - {1'b0, pop};
    push_idx        = count_after_pop[0];

    if (pop) begin
      live_d[0] = live_cancel[1];
      addr_d[0] = addr_q[1];
      data_d[0] = data_q[1];
      live_d[1] = 1'b0;
    end

    // A push only happens with count<2, so the post-pop slot index is 0 or 1.
    if (push) begin
      live_d[push_idx] = 1'b1;
      addr_d[push_idx] = mem_addr_i;
      data_d[push_idx] = mem_data_i;
    end

    count_d = count_after_pop + {1'b0, push};
  end

  always_comb begin
    write_d      = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (alu_valid_i) begin
      write_d      = 1'b1;
      write_addr_d = alu_addr_i;
      write_data_d = alu_data_i;
    end else if (pop_live) begin
      write_d      = 1'b1;
      write_addr_d = addr_q[0];
      write_data_d = data_q[0];
    end

    write_cb_d = alu_cb_valid_i;
    cb_data_d  = alu_cb_valid_i ? alu_cb_i : cb_data_q;
  end

  always_comb begin
    busy = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) begin
        busy = busy | (8'h01 << addr_q[i]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q      <= 2'd0;
      live_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 3'd0;
        data_q[i] <= 8'd0;
      end
      write_q      <= 1'b0;
      write_addr_q <= 3'd0;
      write_data_q <= 8'd0;
      write_cb_q   <= 1'b0;
      cb_data_q    <= 1'b0;
    end else begin
      count_q      <= count_d;
      live_q       <= live_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
      write_q      <= write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      write_cb_q   <= write_cb_d;
      cb_data_q    <= cb_data_d;
    end
  end

  assign write_o      = write_q;
  assign write_addr_o = write_addr_q;
  assign write_data_o = write_data_q;
  assign write_CB_o   = write_cb_q;
  assign cb_data_o    = cb_data_q;
  assign busy_o       = busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile_writeback : directed stimulus with an in-order write scoreboard.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_regfile_writeback;

  logic       clk;
  logic       reset_n;
  logic       alu_valid;
  logic [2:0] alu_addr;
  logic [7:0] alu_data;
  logic       alu_cb_valid;
  logic       alu_cb;
  logic       mem_valid;
  logic       mem_ready;
  logic [2:0] mem_addr;
  logic [7:0] mem_data;
  logic       write;
  logic [2:0] write_addr;
  logic [7:0] write_data;
  logic       write_cb;
  logic       cb_data;
  logic [7:0] busy;

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q [$];
  logic [10:0] mon_exp;

  regfile_writeback dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .alu_valid_i    (alu_valid),
    .alu_addr_i     (alu_addr),
    .alu_data_i     (alu_data),
    .alu_cb_valid_i (alu_cb_valid),
    .alu_cb_i       (alu_cb),
    .mem_valid_i    (mem_valid),
    .mem_ready_o    (mem_ready),
    .mem_addr_i     (mem_addr),
    .mem_data_i     (mem_data),
    .write_o        (write),
    .write_addr_o   (write_addr),
    .write_data_o   (write_data),
    .write_CB_o     (write_cb),
    .cb_data_o      (cb_data),
    .busy_o         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: every regfile write must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n && write) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual addr=%0d data=%h required no write",
                 write_addr, write_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({write_addr, write_data} !== mon_exp) begin
          failures++;
          $display("FAIL write_order actual addr=%0d data=%h required addr=%0d data=%h",
                   write_addr, write_data, mon_exp[10:8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [2:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic idle_inputs();
    alu_valid    = 1'b0;
    alu_addr     = 3'd0;
    alu_data     = 8'd0;
    alu_cb_valid = 1'b0;
    alu_cb       = 1'b0;
    mem_valid    = 1'b0;
    mem_addr     = 3'd0;
    mem_data     = 8'd0;
  endtask

  task automatic alu(input logic [2:0] a, input logic [7:0] d);
    alu_valid = 1'b1;
    alu_addr  = a;
    alu_data  = d;
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_data  = d;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    tick();
    tick();
    chk("rst_write",      {31'd0, write},     32'd0);
    chk("rst_write_addr", {29'd0, write_addr}, 32'd0);
    chk("rst_write_data", {24'd0, write_data}, 32'd0);
    chk("rst_write_cb",   {31'd0, write_cb},  32'd0);
    chk("rst_cb_data",    {31'd0, cb_data},   32'd0);
    chk("rst_busy",       {24'd0, busy},      32'd0);
    chk("rst_mem_ready",  {31'd0, mem_ready}, 32'd1);
    reset_n = 1'b1;
    tick();

    // ALU path: one-cycle latency, then idle.
    alu(3'd3, 8'h5A);
    expect_write(3'd3, 8'h5A);
    tick();
    idle_inputs();
    chk("alu_write_hi", {31'd0, write}, 32'd1);
    tick();
    chk("alu_write_lo", {31'd0, write}, 32'd0);

    // Load latency: busy after accept edge, write one edge later.
    load(3'd5, 8'hC3);
    expect_write(3'd5, 8'hC3);
    tick();
    idle_inputs();
    chk("ld_busy_set",   {24'd0, busy},  32'h20);
    chk("ld_no_write_e", {31'd0, write}, 32'd0);
    tick();
    chk("ld_write_e1",   {31'd0, write}, 32'd1);
    chk("ld_busy_clr",   {24'd0, busy},  32'h00);
    tick();

    // Backpressure: ALU owns the port for three cycles while two loads queue.
    expect_write(3'd7, 8'h77);
    expect_write(3'd7, 8'h77);
    expect_write(3'd7, 8'h77);
    expect_write(3'd1, 8'h11);
    expect_write(3'd2, 8'h22);
    alu(3'd7, 8'h77);
    load(3'd1, 8'h11);
    tick();
    chk("bp_ready_cnt1", {31'd0, mem_ready}, 32'd1);
    load(3'd2, 8'h22);
    tick();
    chk("bp_ready_full", {31'd0, mem_ready}, 32'd0);
    chk("bp_busy_full",  {24'd0, busy},      32'h06);
    mem_valid = 1'b0;
    tick();
    chk("bp_still_full", {31'd0, mem_ready}, 32'd0);
    idle_inputs();
    tick();
    chk("bp_drain1_wr",  {31'd0, write},     32'd1);
    chk("bp_drain1_rdy", {31'd0, mem_ready}, 32'd1);
    tick();
    chk("bp_drain2_wr",  {31'd0, write},     32'd1);
    chk("bp_drain2_busy", {24'd0, busy},     32'h00);
    tick();

    // Cancellation: older queued r4 load killed by a later ALU write to r4.
    load(3'd4, 8'hAA);
    tick();
    idle_inputs();
    chk("cx_busy_live", {24'd0, busy}, 32'h10);
    alu(3'd4, 8'hBB);
    expect_write(3'd4, 8'hBB);
    tick();
    idle_inputs();
    chk("cx_busy_dead", {24'd0, busy}, 32'h00);
    tick();
    chk("cx_dead_pop_wr",  {31'd0, write},      32'd0);
    chk("cx_final_data",   {24'd0, write_data}, 32'hBB);
    chk("cx_ready",        {31'd0, mem_ready},  32'd1);
    tick();

    // Same-edge load is younger than the ALU write: both land, ALU first.
    alu(3'd4, 8'hBB);
    load(3'd4, 8'hAA);
    expect_write(3'd4, 8'hBB);
    expect_write(3'd4, 8'hAA);
    tick();
    idle_inputs();
    chk("se_busy_live", {24'd0, busy}, 32'h10);
    tick();
    chk("se_load_wr",   {31'd0, write},      32'd1);
    chk("se_load_data", {24'd0, write_data}, 32'hAA);
    tick();

    // Conditional bit alongside a load drain, then hold.
    load(3'd6, 8'h66);
    expect_write(3'd6, 8'h66);
    tick();
    idle_inputs();
    alu_cb_valid = 1'b1;
    alu_cb       = 1'b1;
    tick();
    chk("cb_write_en",  {31'd0, write_cb}, 32'd1);
    chk("cb_value",     {31'd0, cb_data},  32'd1);
    chk("cb_load_wr",   {31'd0, write},    32'd1);
    alu_cb_valid = 1'b0;
    alu_cb       = 1'b0;
    tick();
    chk("cb_write_off", {31'd0, write_cb}, 32'd0);
    chk("cb_hold",      {31'd0, cb_data},  32'd1);
    tick();

    // Reset mid-operation with two loads queued behind ALU traffic.
    alu(3'd0, 8'h10);
    load(3'd1, 8'h01);
    expect_write(3'd0, 8'h10);
    tick();
    load(3'd2, 8'h02);
    expect_write(3'd0, 8'h10);
    tick();
    idle_inputs();
    chk("mr_busy_full", {24'd0, busy}, 32'h06);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mr_busy_clr",  {24'd0, busy},      32'h00);
    chk("mr_ready",     {31'd0, mem_ready}, 32'd1);
    chk("mr_write_clr", {31'd0, write},     32'd0);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_load_wr", {31'd0, write}, 32'd0);
    end

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
